// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_prefetch_unit : request/grant instruction prefetcher with in-order
// buffer and redirect flush.          Rev 1.0
// ============================================================================
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  localparam int             AW      = $clog2(DEPTH);
  localparam int             CW      = AW + 1;
  localparam logic [CW:0]    DEPTH_W = DEPTH[CW:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   ret_pc_q, ret_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic [CW:0]   w_inflight;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic          w_unused_pc_lsb;

  // Credit counts both buffered and in-flight words so a response can never overflow the buffer.
  assign w_inflight      = {1'b0, out_q} + {1'b0, cnt_q};
  assign o_mem_req       = !i_rst && !i_redirect && (w_inflight < DEPTH_W);
  assign o_mem_addr      = fetch_pc_q;
  assign w_fire          = o_mem_req && i_mem_gnt;
  assign w_push          = i_mem_rvalid && (disc_q == '0) && !i_redirect;
  assign o_inst_valid    = !i_rst && (cnt_q != '0);
  assign w_pop           = o_inst_valid && i_inst_ready && !i_redirect;
  assign o_inst          = word_q[rd_ptr_q];
  assign o_inst_pc       = pc_q[rd_ptr_q];
  assign w_unused_pc_lsb = ^i_redirect_pc[1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    ret_pc_d   = ret_pc_q;
    out_d      = out_q;
    disc_d     = disc_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (i_redirect) begin
      fetch_pc_d = {i_redirect_pc[31:2], 2'b00};
      ret_pc_d   = {i_redirect_pc[31:2], 2'b00};
      cnt_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Everything still outstanding after this cycle's response is stale.
      out_d      = out_q - CW'(i_mem_rvalid);
      disc_d     = out_q - CW'(i_mem_rvalid);
    end else begin
      if (w_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      out_d = out_q + CW'(w_fire) - CW'(i_mem_rvalid);
      if (i_mem_rvalid) begin
        if (disc_q != '0) begin
          disc_d = disc_q - CW'(1);
        end else begin
          ret_pc_d = ret_pc_q + 32'd4;
        end
      end
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_pc_q <= RESET_ADDR;
      ret_pc_q   <= RESET_ADDR;
      out_q      <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ret_pc_q   <= ret_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      word_q[wr_ptr_q] <= i_mem_rdata;
      pc_q[wr_ptr_q]   <= ret_pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_prefetch_unit : scoreboard bench with a latency-programmable
// in-order memory model.              Rev 1.0
// ============================================================================
module tb_fetch_prefetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RADDR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_gnt = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;

  fetch_prefetch_unit #(.RESET_ADDR(RADDR), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .i_inst_ready(i_inst_ready), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;
  exp_t  exp_q[$];
  pend_t pend_q[$];

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  int          gnt_cnt = 0;
  logic        gnt_en = 1'b1;
  logic        ready_n = 1'b0;
  logic        redir_n = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] redir_pc_n = '0;
  logic        fire = 1'b0;
  logic [31:0] fire_addr = '0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_push(input logic [31:0] a);
    exp_q.push_back('{a, a});
  endtask

  // One clock cycle: drive at negedge, model memory, sample 1 ns later.
  task automatic tick();
    @(negedge clk);
    cyc++;
    i_rst         = rst_n;
    i_redirect    = redir_n;
    i_redirect_pc = redir_pc_n;
    i_inst_ready  = ready_n;
    i_mem_gnt     = gnt_en;
    if (fire) pend_q.push_back('{fire_addr, cyc - 1 + lat});
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = '0;
    if (i_rst) begin
      pend_q.delete();
    end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = pend_q[0].addr;
      void'(pend_q.pop_front());
    end
    #1;
    if (i_rst) begin
      chk("rst_req_low", o_mem_req, 0);
      chk("rst_valid_low", o_inst_valid, 0);
      fire = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !i_redirect) begin
        chk("stall_req_hold", o_mem_req, 1);
        chk("stall_addr_hold", o_mem_addr, prev_addr);
      end
      fire       = o_mem_req && i_mem_gnt;
      fire_addr  = o_mem_addr;
      if (fire) gnt_cnt++;
      prev_stall = o_mem_req && !i_mem_gnt;
      prev_addr  = o_mem_addr;
      chk("inv_credit", 32'(int'(dut.out_q) + int'(dut.cnt_q) <= DEPTH), 1);
      chk("inv_discard", 32'(dut.disc_q <= dut.out_q), 1);
    end
    #2;
  endtask

  // Monitor: every accepted instruction is matched against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (!i_rst && !i_redirect && o_inst_valid && i_inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst: got pc %h inst %h expected nothing", o_inst_pc, o_inst);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_inst", o_inst, e.inst);
        chk("sb_pc", o_inst_pc, e.pc);
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    ready_n = 1'b0;
  endtask

  task automatic do_reset();
    chk("leftover", exp_q.size(), 0);
    rst_n   = 1'b1;
    redir_n = 1'b0;
    ready_n = 1'b0;
    tick();
    tick();
    exp_q.delete();
    rst_n   = 1'b0;
    gnt_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Streaming at zero-wait memory
    lat = 1; gnt_en = 1'b1;
    do_reset();
    ready_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_push(RADDR + 32'(4 * i));
    tick();
    chk("t1_req_c0", o_mem_req, 1);
    chk("t1_addr_c0", o_mem_addr, 32'h100);
    chk("t1_valid_c0", o_inst_valid, 0);
    tick();
    chk("t1_valid_c1", o_inst_valid, 0);
    tick();
    chk("t1_valid_c2", o_inst_valid, 1);
    chk("t1_pc_c2", o_inst_pc, 32'h100);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t1_stream_valid", o_inst_valid, 1);
    end
    wait_drain();

    // Back-pressure: credits exhaust at DEPTH
    lat = 1;
    do_reset();
    ready_n = 1'b0;
    repeat (8) tick();
    chk("t2_grants", gnt_cnt, 4);
    chk("t2_req_low", o_mem_req, 0);
    chk("t2_head_pc", o_inst_pc, 32'h100);
    for (int i = 0; i < 5; i++) exp_push(32'h100 + 32'(4 * i));
    ready_n = 1'b1;
    tick();
    chk("t2_req_pop_cycle", o_mem_req, 0);
    tick();
    chk("t2_req_after_pop", o_mem_req, 1);
    chk("t2_addr_after_pop", o_mem_addr, 32'h110);
    wait_drain();

    // Redirect with two stale responses in flight
    lat = 3;
    do_reset();
    ready_n = 1'b1;
    tick();
    tick();
    redir_n = 1'b1; redir_pc_n = 32'h203;
    tick();
    chk("t3_req_redirect", o_mem_req, 0);
    redir_n = 1'b0;
    tick();
    chk("t3_discard", 32'(dut.disc_q), 2);
    chk("t3_req", o_mem_req, 1);
    chk("t3_addr", o_mem_addr, 32'h200);
    chk("t3_valid_c3", o_inst_valid, 0);
    exp_push(32'h200); exp_push(32'h204); exp_push(32'h208);
    tick();
    chk("t3_valid_c4", o_inst_valid, 0);
    tick();
    chk("t3_valid_c5", o_inst_valid, 0);
    wait_drain();

    // Redirect coinciding with a response and a pop
    lat = 2;
    do_reset();
    ready_n = 1'b1;
    exp_push(32'h100);
    repeat (4) tick();
    redir_n = 1'b1; redir_pc_n = 32'h300;
    tick();
    chk("t4_valid_redirect", o_inst_valid, 1);
    chk("t4_pc_redirect", o_inst_pc, 32'h104);
    redir_n = 1'b0;
    tick();
    chk("t4_discard", 32'(dut.disc_q), 1);
    chk("t4_outstanding", 32'(dut.out_q), 1);
    chk("t4_count", 32'(dut.cnt_q), 0);
    chk("t4_valid_c5", o_inst_valid, 0);
    chk("t4_addr", o_mem_addr, 32'h300);
    exp_push(32'h300); exp_push(32'h304);
    tick();
    chk("t4_valid_c6", o_inst_valid, 0);
    tick();
    chk("t4_valid_c7", o_inst_valid, 0);
    wait_drain();

    // Grant withheld for three cycles
    lat = 1; gnt_en = 1'b0;
    do_reset();
    ready_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_req_wait", o_mem_req, 1);
      chk("t5_addr_wait", o_mem_addr, 32'h100);
    end
    gnt_en = 1'b1;
    tick();
    chk("t5_addr_gnt", o_mem_addr, 32'h100);
    tick();
    chk("t5_addr_next", o_mem_addr, 32'h104);
    exp_push(32'h100); exp_push(32'h104);
    wait_drain();

    // Reset mid-stream with 3 buffered and 1 outstanding
    lat = 1; gnt_en = 1'b1;
    do_reset();
    ready_n = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    tick();
    chk("t6_count_pre", 32'(dut.cnt_q), 3);
    chk("t6_out_pre", 32'(dut.out_q), 1);
    rst_n = 1'b0;
    exp_push(32'h100); exp_push(32'h104);
    ready_n = 1'b1;
    tick();
    chk("t6_valid_post", o_inst_valid, 0);
    chk("t6_req_post", o_mem_req, 1);
    chk("t6_addr_post", o_mem_addr, RADDR);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
